// File: rtl/cfu_pkg.sv
// Shared CFU command/response constants and the initiator state encoding.
package cfu_pkg;

    localparam int CFU_FUNC_W = 10;
    localparam int CFU_DATA_W = 32;

    // Bits [9:3] are nonzero, so the accumulate CFU treats this id as "clear, return 0".
    localparam logic [CFU_FUNC_W-1:0] CLEAR_FUNC_ID_DEFAULT = 10'h008;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR_CMD,
        ST_CLR_RSP,
        ST_LOAD,
        ST_CMD,
        ST_RSP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cfu_dot_initiator.sv
// CFU initiator: clears the accumulator, then streams operand pairs one command at a time
// and reports the last response, the completed-command count and a watchdog flag.
module cfu_dot_initiator
    import cfu_pkg::*;
#(
    parameter int                    LEN_W         = 16,
    parameter int                    TIMEOUT       = 1024,
    parameter logic [CFU_FUNC_W-1:0] CLEAR_FUNC_ID = CLEAR_FUNC_ID_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [LEN_W-1:0]      job_len,
    input  logic [CFU_FUNC_W-1:0] job_func_id,

    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [CFU_DATA_W-1:0] op_a,
    input  logic [CFU_DATA_W-1:0] op_b,

    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [CFU_FUNC_W-1:0] cmd_payload_function_id,
    output logic [CFU_DATA_W-1:0] cmd_payload_inputs_0,
    output logic [CFU_DATA_W-1:0] cmd_payload_inputs_1,

    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [CFU_DATA_W-1:0] rsp_payload_outputs_0,

    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [CFU_DATA_W-1:0] done_result,
    output logic [LEN_W-1:0]      done_count,
    output logic                  done_timeout
);

    localparam int                WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_ONE  = WD_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

    state_e                state, state_nxt;
    logic [LEN_W-1:0]      remaining;
    logic [LEN_W-1:0]      count;
    logic [CFU_FUNC_W-1:0] func_q;
    logic [CFU_DATA_W-1:0] result_q;
    logic                  timeout_q;
    logic [WD_W-1:0]       wd_cnt;
    logic                  cmd_valid_q;
    logic [CFU_FUNC_W-1:0] cmd_func_q;
    logic [CFU_DATA_W-1:0] cmd_in0_q;
    logic [CFU_DATA_W-1:0] cmd_in1_q;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (job_valid) state_nxt = ST_CLR_CMD;
            ST_CLR_CMD: if (cmd_ready) state_nxt = ST_CLR_RSP;
            ST_CLR_RSP: begin
                if (rsp_valid)              state_nxt = (remaining == '0) ? ST_DONE : ST_LOAD;
                else if (wd_cnt == WD_LAST) state_nxt = ST_DONE;
            end
            ST_LOAD:    if (op_valid)  state_nxt = ST_CMD;
            ST_CMD:     if (cmd_ready) state_nxt = ST_RSP;
            ST_RSP: begin
                if (rsp_valid)              state_nxt = (remaining == LEN_ONE) ? ST_DONE : ST_LOAD;
                else if (wd_cnt == WD_LAST) state_nxt = ST_DONE;
            end
            ST_DONE:    if (done_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // cmd_valid is only ever set from state/operand inputs, never from cmd_ready.
    // NOTE: registers use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining   <= '0;
            count       <= '0;
            func_q      <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            wd_cnt      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_func_q  <= '0;
            cmd_in0_q   <= '0;
            cmd_in1_q   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (job_valid) begin
                    remaining   <= job_len;
                    func_q      <= job_func_id;
                    count       <= '0;
                    timeout_q   <= 1'b0;
                    cmd_valid_q <= 1'b1;
                    cmd_func_q  <= CLEAR_FUNC_ID;
                    cmd_in0_q   <= '0;
                    cmd_in1_q   <= '0;
                end
                ST_CLR_CMD, ST_CMD: if (cmd_ready) begin
                    cmd_valid_q <= 1'b0;
                    wd_cnt      <= '0;
                end
                ST_CLR_RSP, ST_RSP: begin
                    if (rsp_valid) begin
                        result_q <= rsp_payload_outputs_0;
                        if (state == ST_RSP) begin
                            count     <= count + LEN_ONE;
                            remaining <= remaining - LEN_ONE;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_ONE;
                        if (wd_cnt == WD_LAST) timeout_q <= 1'b1;
                    end
                end
                ST_LOAD: if (op_valid) begin
                    cmd_valid_q <= 1'b1;
                    cmd_func_q  <= func_q;
                    cmd_in0_q   <= op_a;
                    cmd_in1_q   <= op_b;
                end
                default: ;
            endcase
        end
    end

    assign job_ready               = (state == ST_IDLE);
    assign op_ready                = (state == ST_LOAD);
    assign rsp_ready               = (state == ST_CLR_RSP) || (state == ST_RSP);
    assign done_valid              = (state == ST_DONE);
    assign done_result             = result_q;
    assign done_count              = count;
    assign done_timeout            = timeout_q;
    assign cmd_valid               = cmd_valid_q;
    assign cmd_payload_function_id = cmd_func_q;
    assign cmd_payload_inputs_0    = cmd_in0_q;
    assign cmd_payload_inputs_1    = cmd_in1_q;

endmodule

// File: tb/tb_cfu_dot_initiator.sv
// Scoreboard bench for cfu_dot_initiator: accumulate-CFU responder, operand feeder,
// command/done monitors and a job-level reference model.
module tb_cfu_dot_initiator;
    import cfu_pkg::*;

    localparam int          LEN_W        = 16;
    localparam int          TIMEOUT      = 16;
    localparam logic [9:0]  EXP_CLEAR_ID = 10'h008;

    logic              clk = 1'b0;
    logic              reset;
    logic              job_valid, job_ready;
    logic [LEN_W-1:0]  job_len;
    logic [9:0]        job_func_id;
    logic              op_valid, op_ready;
    logic [31:0]       op_a, op_b;
    logic              cmd_valid, cmd_ready;
    logic [9:0]        cmd_payload_function_id;
    logic [31:0]       cmd_payload_inputs_0, cmd_payload_inputs_1;
    logic              rsp_valid, rsp_ready;
    logic [31:0]       rsp_payload_outputs_0;
    logic              done_valid, done_ready;
    logic [31:0]       done_result;
    logic [LEN_W-1:0]  done_count;
    logic              done_timeout;

    always #5 clk = ~clk;

    cfu_dot_initiator #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .CLEAR_FUNC_ID(10'h008)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_func_id(job_func_id),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
        .done_valid(done_valid), .done_ready(done_ready), .done_result(done_result),
        .done_count(done_count), .done_timeout(done_timeout)
    );

    typedef struct { logic [9:0] func; logic [31:0] in0; logic [31:0] in1; } cmd_t;
    typedef struct { logic [31:0] result; logic [LEN_W-1:0] count; logic timeout; } done_t;
    typedef struct { logic [31:0] a; logic [31:0] b; } op_t;

    cmd_t  exp_cmd_q[$];
    done_t exp_done_q[$];
    op_t   op_q[$];

    int total = 0;
    int bad   = 0;

    // Shared knobs set by the stimulus process.
    int stall_cfg = 0, op_gap_pct = 0, rsp_delay_cfg = 0, done_hold_cfg = 0;
    bit mute_ops = 0, spur_req = 0, op_ready_seen = 0;
    int cmd_fires = 0, done_fires = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accumulate CFU lane rule: signed int8 a with +128 offset times signed int8 b.
    function automatic logic [31:0] lane_dot(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++)
            s += (int'($signed(a[8*i +: 8])) + 128) * int'($signed(b[8*i +: 8]));
        return 32'(s);
    endfunction

    // CFU responder: drives cmd_ready, rsp_valid/payload; answers each accepted command.
    initial begin
        logic [31:0] acc = '0;
        logic [31:0] pend_val = '0;
        cmd_t cap;
        bit fire_cmd = 0, fire_rsp = 0, pend = 0, spur_on = 0;
        int delay = 0, wait_cnt = 0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_payload_outputs_0 = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cmd_ready = 1'b0; rsp_valid = 1'b0;
                fire_cmd = 0; fire_rsp = 0; pend = 0; spur_on = 0; wait_cnt = 0;
                continue;
            end
            if (fire_rsp || spur_on) begin
                rsp_valid = 1'b0;
                spur_on = 0;
            end
            if (fire_cmd) begin
                if (cap.func[9:3] != '0) acc = '0;
                else                     acc = acc + lane_dot(cap.in0, cap.in1);
                if (!(mute_ops && cap.func[9:3] == '0)) begin
                    pend = 1; pend_val = acc; delay = rsp_delay_cfg;
                end
            end
            if (pend && !rsp_valid) begin
                if (delay == 0) begin
                    rsp_valid = 1'b1; rsp_payload_outputs_0 = pend_val; pend = 0;
                end else delay--;
            end else if (spur_req && !pend && !rsp_valid) begin
                rsp_valid = 1'b1; rsp_payload_outputs_0 = $urandom; spur_on = 1; spur_req = 0;
                check("spurious_rsp_ready", 80'(rsp_ready), 80'(0));
            end
            if (cmd_valid) begin
                cmd_ready = (wait_cnt >= stall_cfg);
                wait_cnt++;
            end else begin
                cmd_ready = 1'b0;
                wait_cnt = 0;
            end
            fire_cmd = cmd_valid && cmd_ready;
            if (fire_cmd) cap = '{func: cmd_payload_function_id, in0: cmd_payload_inputs_0, in1: cmd_payload_inputs_1};
            fire_rsp = rsp_valid && rsp_ready && !spur_on;
        end
    end

    // Operand feeder and done consumer.
    initial begin
        bit fire_op = 0;
        int dwait = 0;
        op_valid = 1'b0; op_a = '0; op_b = '0; done_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                op_valid = 1'b0; done_ready = 1'b0; fire_op = 0; dwait = 0;
                continue;
            end
            if (fire_op && op_q.size() > 0) void'(op_q.pop_front());
            if (op_valid && !fire_op && op_q.size() > 0) begin
                op_valid = 1'b1;
            end else if (op_q.size() > 0 && $urandom_range(99) >= op_gap_pct) begin
                op_valid = 1'b1; op_a = op_q[0].a; op_b = op_q[0].b;
            end else begin
                op_valid = 1'b0;
            end
            fire_op = op_valid && op_ready;
            if (done_valid) begin
                done_ready = (dwait >= done_hold_cfg);
                dwait++;
            end else begin
                done_ready = 1'b0;
                dwait = 0;
            end
        end
    end

    // Monitor: command and done scoreboards plus stability/ordering checks.
    initial begin
        bit prev_stall = 0, prev_dhold = 0, prev_cmd_valid = 0, outstanding = 0;
        cmd_t  pc, e;
        done_t pd, ed;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                prev_stall = 0; prev_dhold = 0; prev_cmd_valid = 0; outstanding = 0;
                continue;
            end
            if (op_ready) op_ready_seen = 1;
            if (prev_stall) begin
                check("cmd_hold_valid", 80'(cmd_valid), 80'(1));
                check("cmd_hold_payload", {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1},
                      {pc.func, pc.in0, pc.in1});
            end
            if (cmd_valid && !prev_cmd_valid)
                check("cmd_raised_while_outstanding", 80'(outstanding), 80'(0));
            if (cmd_valid && cmd_ready) begin
                cmd_fires++;
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", 80'(1), 80'(0));
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_func", 80'(cmd_payload_function_id), 80'(e.func));
                    check("cmd_in0", 80'(cmd_payload_inputs_0), 80'(e.in0));
                    check("cmd_in1", 80'(cmd_payload_inputs_1), 80'(e.in1));
                end
                outstanding = 1;
            end
            if (rsp_valid && rsp_ready) outstanding = 0;
            prev_cmd_valid = cmd_valid;
            prev_stall = cmd_valid && !cmd_ready;
            pc = '{func: cmd_payload_function_id, in0: cmd_payload_inputs_0, in1: cmd_payload_inputs_1};

            if (prev_dhold) begin
                check("done_hold_valid", 80'(done_valid), 80'(1));
                check("done_hold_fields", {done_result, done_count, done_timeout}, {pd.result, pd.count, pd.timeout});
                check("done_hold_job_ready", 80'(job_ready), 80'(0));
            end
            if (done_valid && done_ready) begin
                done_fires++;
                outstanding = 0;
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", 80'(1), 80'(0));
                end else begin
                    ed = exp_done_q.pop_front();
                    check("done_result", 80'(done_result), 80'(ed.result));
                    check("done_count", 80'(done_count), 80'(ed.count));
                    check("done_timeout", 80'(done_timeout), 80'(ed.timeout));
                end
            end
            prev_dhold = done_valid && !done_ready;
            pd = '{result: done_result, count: done_count, timeout: done_timeout};
        end
    end

    // Issue one job, push its expected commands and done tuple, wait for completion.
    // rsp_run reports how many consecutive cycles rsp_ready was high just before done_valid.
    task automatic run_job(input int len, input logic [9:0] func, input op_t ops[$],
                           input bit mute, input bit spur, output int rsp_run);
        logic [31:0] acc = '0;
        int target, n, run;
        bit done_seen = 0;
        mute_ops = mute;
        exp_cmd_q.push_back('{func: EXP_CLEAR_ID, in0: 32'h0, in1: 32'h0});
        foreach (ops[i]) begin
            op_q.push_back(ops[i]);
            if (!mute || i == 0) exp_cmd_q.push_back('{func: func, in0: ops[i].a, in1: ops[i].b});
            acc = (func[9:3] != '0) ? 32'h0 : acc + lane_dot(ops[i].a, ops[i].b);
        end
        if (mute) exp_done_q.push_back('{result: 32'h0, count: '0, timeout: 1'b1});
        else      exp_done_q.push_back('{result: acc, count: LEN_W'(len), timeout: 1'b0});
        target = done_fires + 1;
        job_valid = 1'b1; job_len = LEN_W'(len); job_func_id = func;
        n = 0;
        while (!job_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        job_valid = 1'b0;
        n = 0; run = 0;
        while (done_fires < target && n < 3000) begin
            @(negedge clk);
            n++;
            if (!done_seen) begin
                if (done_valid) begin
                    done_seen = 1;
                    if (spur) spur_req = 1;
                end else if (rsp_ready) run++;
                else run = 0;
            end
        end
        check("job_completed", 80'(done_fires >= target), 80'(1));
        rsp_run = run;
        op_q.delete();
        mute_ops = 0;
        @(negedge clk);
    endtask

    initial begin
        op_t ops[$];
        int run, base, n;
        reset = 1'b1; job_valid = 1'b0; job_len = '0; job_func_id = '0;
        repeat (3) @(negedge clk);
        check("rst_job_ready", 80'(job_ready), 80'(1));
        check("rst_cmd_valid", 80'(cmd_valid), 80'(0));
        check("rst_cmd_payload", {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, 80'(0));
        check("rst_rsp_ready", 80'(rsp_ready), 80'(0));
        check("rst_op_ready", 80'(op_ready), 80'(0));
        check("rst_done", {done_valid, done_result, done_count, done_timeout}, 80'(0));
        reset = 1'b0;
        @(negedge clk);

        // Basic two-pair job.
        ops = {};
        repeat (2) ops.push_back('{a: 32'h0000_0000, b: 32'h0101_0101});
        run_job(2, 10'h000, ops, 0, 0, run);

        // Zero-length job: only the clear command, operand port never opens.
        ops = {}; base = cmd_fires; op_ready_seen = 0;
        run_job(0, 10'h003, ops, 0, 0, run);
        check("len0_cmd_count", 80'(cmd_fires - base), 80'(1));
        check("len0_op_ready_seen", 80'(op_ready_seen), 80'(0));

        // Backpressure on commands, gapped operands, lanes contribute zero.
        stall_cfg = 5; op_gap_pct = 50;
        ops = {};
        repeat (3) ops.push_back('{a: 32'h8080_8080, b: $urandom});
        run_job(3, 10'h000, ops, 0, 0, run);
        stall_cfg = 0; op_gap_pct = 0;

        // Watchdog: first operand command is never answered.
        ops = {};
        ops.push_back('{a: $urandom, b: $urandom});
        run_job(1, 10'h000, ops, 1, 0, run);
        check("timeout_rsp_cycles", 80'(run), 80'(TIMEOUT));

        // Reset while an operand command is stalled.
        stall_cfg = 50;
        exp_cmd_q.push_back('{func: EXP_CLEAR_ID, in0: 32'h0, in1: 32'h0});
        exp_cmd_q.push_back('{func: 10'h001, in0: 32'h1111_1111, in1: 32'h2222_2222});
        op_q.push_back('{a: 32'h1111_1111, b: 32'h2222_2222});
        base = cmd_fires;
        job_valid = 1'b1; job_len = LEN_W'(1); job_func_id = 10'h001;
        @(negedge clk);
        job_valid = 1'b0;
        n = 0;
        while (!(cmd_fires > base && cmd_valid) && n < 500) begin @(negedge clk); n++; end
        check("reset_setup_cmd_stalled", 80'(cmd_valid && !cmd_ready), 80'(1));
        reset = 1'b1;
        exp_cmd_q.delete(); exp_done_q.delete(); op_q.delete();
        @(negedge clk);
        check("reset_mid_cmd_valid", 80'(cmd_valid), 80'(0));
        check("reset_mid_job_ready", 80'(job_ready), 80'(1));
        @(negedge clk);
        reset = 1'b0; stall_cfg = 0;
        @(negedge clk);
        ops = {};
        ops.push_back('{a: 32'h0101_0101, b: 32'h0202_0202});
        run_job(1, 10'h000, ops, 0, 0, run);

        // DONE held for 10 cycles with a stray response during DONE.
        done_hold_cfg = 10;
        ops = {};
        repeat (2) ops.push_back('{a: $urandom, b: $urandom});
        run_job(2, 10'h002, ops, 0, 1, run);
        done_hold_cfg = 0;

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            int len;
            logic [9:0] func;
            len = $urandom_range(6);
            func = ($urandom_range(9) == 0) ? 10'h010 : 10'($urandom_range(7));
            stall_cfg = $urandom_range(3); op_gap_pct = $urandom_range(60);
            rsp_delay_cfg = $urandom_range(4); done_hold_cfg = $urandom_range(3);
            ops = {};
            for (int k = 0; k < len; k++) ops.push_back('{a: $urandom, b: $urandom});
            run_job(len, func, ops, 0, 0, run);
        end

        check("cmd_queue_drained", 80'(exp_cmd_q.size()), 80'(0));
        check("done_queue_drained", 80'(exp_done_q.size()), 80'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfu_dot_initiator.md
Name: cfu_dot_initiator

Overview:
- Initiator side of the CFU command/response interface: drives cmd_* and consumes rsp_* of an accumulate-style SIMD CFU.
- Accepts a job descriptor (length, function id), then streams operand word pairs from an operand stream into the CFU as one outstanding command at a time.
- Before the operands, issues one accumulator-clear command; returns the final response word plus status on a done channel.
- Sits between a DMA/operand fetcher and the CFU, letting dot products run without CPU involvement.

Parameters:
- LEN_W, 16, width of job length and completed-command counters.
- TIMEOUT, 1024, max cycles waiting for rsp_valid before aborting the job (must be >= 2).
- CLEAR_FUNC_ID, 10'h008, function id used for the clear command (bits [9:3] nonzero, so the CFU returns 0).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- job_valid  in  1  job descriptor valid
- job_ready  out  1  high only in IDLE
- job_len  in  LEN_W  number of operand pairs (0 allowed)
- job_func_id  in  10  function id for operand commands
- op_valid  in  1  operand pair valid
- op_ready  out  1  operand pair accepted
- op_a  in  32  goes to cmd_payload_inputs_0
- op_b  in  32  goes to cmd_payload_inputs_1
- cmd_valid  out  1  command valid to CFU
- cmd_ready  in  1  CFU accepts command
- cmd_payload_function_id  out  10
- cmd_payload_inputs_0  out  32
- cmd_payload_inputs_1  out  32
- rsp_valid  in  1  CFU response valid
- rsp_ready  out  1  initiator accepts response
- rsp_payload_outputs_0  in  32  CFU result
- done_valid  out  1  job complete
- done_ready  in  1  done consumed
- done_result  out  32  last response captured
- done_count  out  LEN_W  operand commands completed (clear command excluded)
- done_timeout  out  1  job aborted by watchdog

Behaviour:
- Reset: state IDLE. All outputs low/zero: cmd_valid, cmd payloads, rsp_ready, op_ready, done_valid, done_result, done_count, done_timeout. job_ready is 1 after reset. Reset mid-job abandons the job immediately; no command is reissued.
- States: IDLE, CLR_CMD, CLR_RSP, LOAD, CMD, RSP, DONE.
- IDLE: job_ready=1. On job_valid, latch job_len into remaining and job_func_id, clear count and timeout flag, then go to CLR_CMD.
- CLR_CMD:
  - Register cmd_valid=1, function_id=CLEAR_FUNC_ID, inputs=0.
  - On cmd_valid&&cmd_ready, drop cmd_valid and go to CLR_RSP.
- CLR_RSP: rsp_ready=1. On rsp_valid, capture outputs_0 into done_result. Go to DONE if remaining==0, else LOAD.
- LOAD:
  - op_ready=1 for exactly this state.
  - On op_valid, register op_a/op_b/job_func_id into the cmd payload, set cmd_valid=1 next cycle, and go to CMD.
- CMD:
  - cmd_valid and payloads are registered and held stable until cmd_ready.
  - cmd_valid never depends combinationally on cmd_ready.
  - On handshake, drop cmd_valid and go to RSP.
- RSP: rsp_ready=1 (combinational from state). On rsp_valid:
  - capture the result;
  - count+1, remaining-1;
  - go to DONE if remaining becomes 0, else LOAD.
- Only one command is outstanding at a time. A new cmd_valid is never raised before the previous response handshake.
- Throughput: best case 3 cycles per pair (LOAD, CMD, RSP), with a CFU that has 1-cycle response latency.
- Watchdog:
  - A cycle counter resets on entry to CLR_RSP or RSP and counts while waiting.
  - On reaching TIMEOUT with no rsp_valid, set done_timeout=1 and go to DONE; done_result holds the last captured value.
  - rsp_valid and TIMEOUT in the same cycle: the response wins and no timeout is flagged.
- DONE:
  - done_valid=1; hold done_result, done_count and done_timeout until done_ready, then go to IDLE.
  - rsp_ready=0 in DONE.
- Unsolicited rsp_valid (in IDLE, LOAD, CMD, CLR_CMD or DONE): rsp_ready=0; it is ignored and counters are unaffected.
- job_len=0: only the clear command is issued; result is 0 and count is 0.
- Counter widths: remaining and count are LEN_W bits. Max job length is 2^LEN_W-1 with no wrap.

Decomposition:
- Shared package cfu_pkg:
  - state enum;
  - CLEAR_FUNC_ID default;
  - CFU function-id width 10 and data width 32 constants.
- No sub-module needed. The watchdog counter is inline; the cmd payload register is inline.

Test Plan:
- Bench CFU model computes acc += sum((a_i+128)*b_i) per byte lane, with 1-cycle response; clear when function_id[9:3]!=0.
- Basic: job_len=2, func=0, ops {a=0x00000000,b=0x01010101} twice -> 2 cmds + 1 clear; done_result=1024, done_count=2, timeout=0.
- job_len=0 -> exactly one cmd with function_id=0x008; done_result=0, count=0; op_ready never high.
- Backpressure: cmd_ready low 5 cycles and op_valid gapped randomly; job_len=3, a=0x80808080 (lanes contribute 0) -> payload stable while stalled; result=0, count=3.
- Timeout: CFU stops responding after first operand cmd, TIMEOUT=16 -> done_timeout=1 exactly 16 cycles into RSP; count=0; done_result=0 (the clear response).
- Reset mid-CMD with cmd_valid=1 -> next cycle cmd_valid=0, job_ready=1; a new job with len=1, a=0x01010101, b=0x02020202 -> result 4*129*2=1032.
- Done hold: done_ready low 10 cycles -> done_* stable, job_ready=0; a spurious rsp_valid during DONE is ignored.
